// File: rtl/game_loader.sv
// Builds a random 8-note pattern from a 16-bit LFSR, hands it to the game block
// with write_enable, then sequences game_reset/game_start and counts finished games.
module game_loader #(
    parameter int SETTLE_CYCLES = 4,
    parameter bit NO_REPEAT     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        abort,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        game_end,
    output logic [31:0] data_out,
    output logic        write_enable,
    output logic        game_start,
    output logic        game_reset,
    output logic        busy,
    output logic [7:0]  round_count
);

    typedef enum logic [2:0] {IDLE, GEN, CLR, WRITE, SETTLE, START, PLAY} state_t;

    localparam logic [15:0] LFSR_INIT   = 16'hACE1;
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [2:0]  gen_idx;
    logic [2:0]  prev_note;
    logic [2:0]  note;
    logic [3:0]  settle_cnt;
    logic        start_prev;
    logic        start_armed;
    logic        start_edge;

    always_comb begin
        lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        note      = lfsr_next[2:0];
        if (NO_REPEAT && gen_idx != 3'd0 && note == prev_note) begin
            note = note + 3'd1;
        end
    end

    // start_armed blocks a button that was already held when reset was released
    assign start_edge = start_armed && !start_prev && start_btn;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lfsr         <= LFSR_INIT;
            data_out     <= 32'h0;
            round_count  <= 8'h0;
            write_enable <= 1'b0;
            game_start   <= 1'b0;
            game_reset   <= 1'b0;
            busy         <= 1'b0;
            start_prev   <= 1'b0;
            start_armed  <= 1'b0;
            gen_idx      <= 3'd0;
            prev_note    <= 3'd0;
            settle_cnt   <= 4'd0;
        end else begin
            start_prev   <= start_btn;
            start_armed  <= start_armed | ~start_btn;
            write_enable <= 1'b0;
            game_start   <= 1'b0;
            game_reset   <= 1'b0;

            if (state != IDLE && abort) begin
                game_reset <= 1'b1;
                busy       <= 1'b0;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (seed_load) begin
                            lfsr <= (seed == 16'h0) ? LFSR_INIT : seed;
                        end
                        if (start_edge) begin
                            state    <= GEN;
                            busy     <= 1'b1;
                            data_out <= 32'h0;
                            gen_idx  <= 3'd0;
                        end
                    end
                    GEN: begin
                        lfsr                          <= lfsr_next;
                        data_out[{gen_idx, 2'b00} +: 4] <= {1'b0, note};
                        prev_note                     <= note;
                        gen_idx                       <= gen_idx + 3'd1;
                        if (gen_idx == 3'd7) begin
                            state <= CLR;
                        end
                    end
                    CLR: begin
                        game_reset <= 1'b1;
                        state      <= WRITE;
                    end
                    WRITE: begin
                        write_enable <= 1'b1;
                        settle_cnt   <= 4'd0;
                        state        <= SETTLE;
                    end
                    SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= START;
                        end else begin
                            settle_cnt <= settle_cnt + 4'd1;
                        end
                    end
                    START: begin
                        game_start <= 1'b1;
                        state      <= PLAY;
                    end
                    PLAY: begin
                        if (game_end) begin
                            if (round_count != 8'hFF) begin
                                round_count <= round_count + 8'd1;
                            end
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_loader.sv
// Randomized bench for game_loader: a pattern/timing reference model predicts
// data_out, strobe timing, busy and round_count for every game.
module tb_game_loader;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_btn = 1'b0;
    logic        abort = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'h0;
    logic        game_end = 1'b0;
    logic [31:0] data_out;
    logic        write_enable;
    logic        game_start;
    logic        game_reset;
    logic        busy;
    logic [7:0]  round_count;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] mLfsr = 16'hACE1;
    logic [7:0]  mRound = 8'h0;
    logic [31:0] mData = 32'h0;

    game_loader #(.SETTLE_CYCLES(SETTLE), .NO_REPEAT(1'b1)) dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .abort(abort),
        .seed_load(seed_load), .seed(seed), .game_end(game_end),
        .data_out(data_out), .write_enable(write_enable), .game_start(game_start),
        .game_reset(game_reset), .busy(busy), .round_count(round_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Feedback is the XOR of the tapped positions 16,14,13,11 (1-based)
    function automatic logic [15:0] lfsrStep(input logic [15:0] x);
        int taps[4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[i]) fb ^= x[taps[i] - 1];
        return {x[14:0], fb};
    endfunction

    function automatic int countAdjEqual(input logic [31:0] d);
        int n = 0;
        for (int k = 1; k < 8; k++) begin
            if (d[4*k +: 3] == d[4*(k-1) +: 3]) n++;
        end
        return n;
    endfunction

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_strobes"}, {29'h0, game_reset, write_enable, game_start}, 32'h0);
        checkOutput({tag, "_busy"}, {31'h0, busy}, 32'h0);
        checkOutput({tag, "_data"}, data_out, mData);
        checkOutput({tag, "_round"}, {24'h0, round_count}, {24'h0, mRound});
    endtask

    // One complete game; abortAt selects the post-start cycle carrying abort (0 = none)
    task automatic applyStimulus(input bit doSeed, input logic [15:0] seedVal, input int abortAt,
                                 input int playLen, input bit endWithAbort);
        logic [2:0]  notes[8];
        logic [15:0] lf[8];
        logic [15:0] x;
        logic [2:0]  c;
        logic [2:0]  expStrobe;

        seed_load = doSeed;
        seed      = seedVal;
        start_btn = 1'b1;
        tick();
        if (doSeed) mLfsr = (seedVal == 16'h0) ? 16'hACE1 : seedVal;
        seed_load = 1'b0;

        x = mLfsr;
        for (int k = 0; k < 8; k++) begin
            x = lfsrStep(x);
            lf[k] = x;
            c = x[2:0];
            if (k > 0 && c == notes[k-1]) c = c + 3'd1;
            notes[k] = c;
        end
        mData = 32'h0;
        checkOutput("start_data", data_out, 32'h0);
        checkOutput("start_busy", {31'h0, busy}, 32'h1);

        for (int j = 1; j <= 11 + SETTLE; j++) begin
            start_btn = 1'($urandom_range(0, 1));
            seed_load = 1'($urandom_range(0, 1));
            seed      = 16'($urandom);
            abort     = (j == abortAt);
            tick();
            if (j <= 8 && j != abortAt) begin
                mData[4*(j-1) +: 3] = notes[j-1];
                mLfsr = lf[j-1];
            end
            if (j == abortAt)          expStrobe = 3'b100;
            else if (j == 9)           expStrobe = 3'b100;
            else if (j == 10)          expStrobe = 3'b010;
            else if (j == 11 + SETTLE) expStrobe = 3'b001;
            else                       expStrobe = 3'b000;
            checkOutput($sformatf("strobes_c%0d", j), {29'h0, game_reset, write_enable, game_start},
                        {29'h0, expStrobe});
            if (j == abortAt) begin
                abort = 1'b0;
                seed_load = 1'b0;
                start_btn = 1'b0;
                checkOutput("abort_busy", {31'h0, busy}, 32'h0);
                checkOutput("abort_data", data_out, mData);
                checkOutput("abort_round", {24'h0, round_count}, {24'h0, mRound});
                tick();
                checkIdleOutputs("after_abort");
                return;
            end
            checkOutput($sformatf("busy_c%0d", j), {31'h0, busy}, 32'h1);
            if (j == 10) begin
                checkOutput("pattern", data_out, mData);
                checkOutput("pad_bits", data_out & 32'h8888_8888, 32'h0);
                checkOutput("adjacent_eq", 32'(countAdjEqual(data_out)), 32'h0);
            end
        end

        for (int p = 0; p < playLen; p++) begin
            start_btn = 1'($urandom_range(0, 1));
            seed_load = 1'($urandom_range(0, 1));
            seed      = 16'($urandom);
            tick();
            checkOutput("play_strobes", {29'h0, game_reset, write_enable, game_start}, 32'h0);
            checkOutput("play_busy", {31'h0, busy}, 32'h1);
        end

        start_btn = 1'b0;
        seed_load = 1'b0;
        tick();
        game_end = 1'b1;
        abort    = endWithAbort;
        tick();
        if (!endWithAbort && mRound != 8'hFF) mRound = mRound + 8'd1;
        checkOutput("end_strobes", {29'h0, game_reset, write_enable, game_start},
                    endWithAbort ? 32'h4 : 32'h0);
        checkOutput("end_busy", {31'h0, busy}, 32'h0);
        checkOutput("end_round", {24'h0, round_count}, {24'h0, mRound});
        checkOutput("end_data", data_out, mData);
        game_end = 1'b0;
        abort    = 1'b0;
        tick();
        checkIdleOutputs("idle");
    endtask

    task automatic pulseReset(input bit holdStart);
        start_btn = holdStart;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        mLfsr = 16'hACE1;
        mRound = 8'h0;
        mData = 32'h0;
        checkIdleOutputs("reset");
        for (int i = 0; i < 6; i++) begin
            tick();
            checkIdleOutputs("held_start");
        end
        start_btn = 1'b0;
        tick();
    endtask

    initial begin
        start_btn = 1'b1;
        tick();
        pulseReset(1'b1);

        applyStimulus(1'b1, 16'h1234, 0, 3, 1'b0);

        pulseReset(1'b0);
        applyStimulus(1'b0, 16'h0, 0, 1, 1'b0);
        applyStimulus(1'b0, 16'h0, 0, 0, 1'b1);
        pulseReset(1'b0);
        applyStimulus(1'b1, 16'h0, 0, 2, 1'b0);

        applyStimulus(1'b1, 16'hBEEF, 11 + SETTLE / 2, 0, 1'b0);
        applyStimulus(1'b0, 16'h0, 0, 2, 1'b1);

        for (int g = 0; g < 24; g++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom),
                          ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 11 + SETTLE)) : 0,
                          int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0));
        end

        // Reset in the fifth GEN cycle with the button still held
        start_btn = 1'b1;
        tick();
        for (int j = 1; j <= 4; j++) tick();
        pulseReset(1'b1);
        applyStimulus(1'b0, 16'h0, 0, 1, 1'b0);

        for (int g = 0; g < 260; g++) begin
            applyStimulus(1'b0, 16'h0, 0, 0, 1'b0);
        end
        checkOutput("saturated", {24'h0, round_count}, 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/game_loader.md
GAME_LOADER -- requirements
Module: game_loader

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, is the number of idle cycles between write_enable and game_start; legal range 1..15.
REQ-002 Parameter NO_REPEAT, default 1, forbids equal adjacent notes in a pattern when 1.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start_btn  input  1  level from the start button; the rising edge requests a new game.
REQ-006 abort  input  1  level; ends the current game.
REQ-007 seed_load  input  1  level; loads seed into the LFSR.
REQ-008 seed  input  16  LFSR seed value.
REQ-009 game_end  input  1  level from the game block; high when all notes have been answered.
REQ-010 data_out  output  32  packed 8-note pattern.
REQ-011 write_enable  output  1  one-cycle strobe that qualifies data_out.
REQ-012 game_start  output  1  one-cycle strobe that starts play.
REQ-013 game_reset  output  1  one-cycle strobe that clears the game block.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 round_count  output  8  number of completed games.

Function
REQ-016 Data format: note k (k=0..7) occupies data_out[4k+2:4k] with value 0..7; data_out[4k+3] SHALL be 0.
REQ-017 LFSR: 16-bit Fibonacci LFSR, taps 16,14,13,11; shifts left with feedback into bit 0.
REQ-018 FSM states: IDLE, GEN, CLR, WRITE, SETTLE, START, PLAY.
REQ-019 IDLE: a start_btn rising edge (registered previous sample is 0, current sample is 1) SHALL move the FSM to GEN and clear data_out to 0.
REQ-020 GEN lasts exactly 8 cycles. In cycle k the LFSR advances once, the candidate note is the advanced value [2:0], and the candidate is written to note k.
REQ-021 When NO_REPEAT=1, k>0 and the candidate equals note k-1, the note written SHALL be (candidate+1) mod 8.
REQ-022 CLR: game_reset SHALL be high for 1 cycle; the next state is WRITE.
REQ-023 WRITE: write_enable SHALL be high for 1 cycle. data_out SHALL then hold its value until the next GEN or until reset.
REQ-024 SETTLE: SETTLE_CYCLES cycles with all strobes low; the next state is START.
REQ-025 START: game_start SHALL be high for 1 cycle; the next state is PLAY.
REQ-026 Latency: if the start edge is sampled at cycle N, then game_reset is at N+9, write_enable at N+10, and game_start at N+11+SETTLE_CYCLES.
REQ-027 PLAY: when game_end=1, round_count SHALL increment, saturating at 255, and the FSM SHALL go to IDLE.
REQ-028 abort=1 in any non-IDLE state SHALL pulse game_reset for 1 cycle and go to IDLE. round_count and data_out are unchanged in this case.
REQ-029 abort and game_end both high in PLAY: abort wins and round_count does not increment.
REQ-030 seed_load is honoured only in IDLE; it loads the LFSR with seed, or with 16'hACE1 when seed is 0.
REQ-031 seed_load and a start edge in the same IDLE cycle: the seed is loaded and GEN starts from the loaded value.
REQ-032 A start_btn edge outside IDLE SHALL be ignored; the edge detector keeps sampling in all states.
REQ-033 At most one of write_enable, game_start and game_reset SHALL be high in any cycle.

Reset
REQ-034 reset SHALL set: state IDLE, LFSR 16'hACE1, data_out 0, round_count 0, all strobes 0, busy 0, and start_btn sample register 0.
REQ-035 reset SHALL take priority over every other input, including mid-GEN and mid-PLAY; after reset no strobe fires until a new start edge.
REQ-036 start_btn held high through the release of reset SHALL NOT start a game; a fresh 0->1 transition is required.

Verification
REQ-037 Reset, seed_load with seed 16'h1234, start edge at cycle N, SETTLE=4 -> game_reset at N+9, write_enable at N+10, game_start at N+15; data_out matches a reference LFSR model; bits 3,7,...,31 are 0; no two adjacent notes are equal.
REQ-038 seed_load with seed 0 -> pattern identical to the pattern produced after reset (LFSR 16'hACE1).
REQ-039 Complete a game, then assert game_end in PLAY -> round_count goes 0->1 and busy goes low on the next cycle; 256 completed games leave round_count at 255.
REQ-040 abort during SETTLE -> game_reset for 1 cycle, no game_start, IDLE, round_count unchanged; abort and game_end together in PLAY -> no increment.
REQ-041 reset during GEN cycle 4 -> all outputs return to their reset values; no write_enable follows; a held start_btn does not retrigger.
REQ-042 Start edge while in PLAY -> ignored, no strobes; seed_load while in PLAY -> LFSR unchanged (the next pattern equals the expected continuation).
